pong_ctrl: RTL and testbench
============================

PONG_CTRL -- requirements
Module: pong_ctrl

Interface
REQ-001 DEBOUNCE_FRAMES, 3, consecutive frame ticks a synchronized button level must hold before being accepted (range 1..15).
REQ-002 SERVE_FRAMES, 60, frame ticks spent in SERVE before play resumes (range 1..255).
REQ-003 LIVES_INIT, 3, lives loaded at reset and at new game (range 1..3).
REQ-004 vga_clk  in  1  single block clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 btn_up, btn_down  in  1 each  raw asynchronous push-buttons, active-high.
REQ-007 vsync  in  1  frame sync from VGA driver, active-low pulse.
REQ-008 ball_hit  in  1  one-cycle pulse: ball returned by paddle.
REQ-009 ball_miss  in  1  one-cycle pulse: ball passed paddle.
REQ-010 paddle_up, paddle_down  out  1 each  debounced button levels.
REQ-011 run  out  1  ball motion enable.
REQ-012 serve  out  1  one-cycle pulse: recentre ball.
REQ-013 score  out  8  hit count, saturating.
REQ-014 lives  out  2  remaining lives.
REQ-015 state  out  3  current FSM state encoding.
REQ-016 game_over  out  1  high only in OVER.

Function
REQ-017 frame_tick SHALL be a one-cycle internal pulse on each vsync 1->0 transition, detected on a registered copy of vsync.
REQ-018 Each button SHALL pass a 2-flop synchronizer; debounced level SHALL change only on a frame_tick after the synchronized level differed from it for DEBOUNCE_FRAMES consecutive frame_ticks; any tick showing agreement SHALL clear the count.
REQ-019 press event SHALL be a one-cycle pulse on a debounced 0->1 of either button; both pressing in one cycle SHALL give one event.
REQ-020 States: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4; other codes SHALL return to IDLE next cycle.
REQ-021 IDLE: run=0; press -> SERVE, score<=0, lives<=LIVES_INIT, serve pulses that cycle.
REQ-022 SERVE: run=0; frame counter cleared on entry, increments per frame_tick; on reaching SERVE_FRAMES -> PLAY.
REQ-023 PLAY: run=1; ball_hit SHALL increment score, holding at 255; ball_miss -> MISS.
REQ-024 ball_hit and ball_miss in the same cycle: miss SHALL win, score unchanged.
REQ-025 ball_hit/ball_miss outside PLAY SHALL be ignored.
REQ-026 MISS (one cycle): run=0; lives decrements; if lives was 1 -> OVER, else -> SERVE with serve pulse.
REQ-027 OVER: game_over=1, run=0, score and lives held; press -> IDLE.
REQ-028 run SHALL be registered, valid the cycle the state register shows PLAY; latency input-pulse-to-state change = 1 cycle.

Reset
REQ-029 On rst low all outputs SHALL clear immediately except lives=LIVES_INIT; state=IDLE; debounce counters, synchronizers, frame counter = 0.
REQ-030 Reset release mid-game SHALL resume in IDLE with no serve pulse.

Structure
REQ-031 Shared package pong_pkg SHALL hold state encodings, SCORE_MAX=255 and LIVES_INIT default.
REQ-032 Sub-module btn_debounce (sync + counter + level), instantiated twice; pong_ctrl owns FSM, frame-tick detect, counters.

Verification
REQ-033 btn_up high 3 frames (DEBOUNCE_FRAMES=3) -> paddle_up rises on 3rd tick; 2-frame glitch -> no change.
REQ-034 From IDLE press -> serve pulse, SERVE; SERVE_FRAMES=4 -> run=1 after 4th frame_tick.
REQ-035 PLAY with 256 ball_hit pulses -> score=255 held.
REQ-036 Simultaneous hit+miss with score=5, lives=3 -> score=5, lives=2, SERVE.
REQ-037 Three misses -> lives=0, game_over=1; press -> IDLE, then press -> score=0, lives=3.
REQ-038 rst low during PLAY -> run=0, state=IDLE, lives=3 asynchronously.

Source files
------------

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game controller: FSM state encodings,
// score ceiling and default timing/lives parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package pong_pkg;

  // Encodings are visible on the state output, so they are pinned explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } pong_state_e;

  localparam logic [7:0] SCORE_MAX = 8'd255;

  localparam int DEBOUNCE_FRAMES_DEFAULT = 3;
  localparam int SERVE_FRAMES_DEFAULT    = 60;
  localparam int LIVES_INIT_DEFAULT      = 3;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes one raw push-button into the clock domain and debounces it at
// frame rate: the accepted level only follows the synchronized input after it
// has disagreed for DEBOUNCE_FRAMES consecutive frame ticks.
// Ports:
//   clk_i        block clock, rising edge
//   rst_ni       asynchronous active-low reset
//   frame_tick_i one-cycle pulse per video frame
//   btn_i        raw asynchronous button, active-high
//   level_o      debounced button level
// -----------------------------------------------------------------------------
module btn_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_tick_i,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [3:0] DebounceLast = 4'(DEBOUNCE_FRAMES);

  logic syncMeta_q;
  logic syncOut_q;
  logic [3:0] count_q;
  logic level_q;

  // Two-flop synchronizer followed by a frame-rate disagreement counter.
  // The counter only advances on frame ticks where the synchronized input
  // differs from the accepted level; any tick that agrees throws away the
  // partial count, so a short glitch never accumulates across frames.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
      count_q    <= 4'd0;
      level_q    <= 1'b0;
    end else begin
      syncMeta_q <= btn_i;
      syncOut_q  <= syncMeta_q;
      if (frame_tick_i) begin
        if (syncOut_q != level_q) begin
          if (count_q + 4'd1 == DebounceLast) begin
            level_q <= syncOut_q;
            count_q <= 4'd0;
          end else begin
            count_q <= count_q + 4'd1;
          end
        end else begin
          count_q <= 4'd0;
        end
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pong_ctrl.sv
// -----------------------------------------------------------------------------
// pong_ctrl
// Game-flow controller for a VGA pong game: frame-tick extraction from vsync,
// debounced paddle buttons, serve timing, score and lives bookkeeping.
// Ports:
//   vga_clk_i     block clock, rising edge
//   rst_ni        asynchronous active-low reset
//   btn_up_i      raw up button, active-high
//   btn_down_i    raw down button, active-high
//   vsync_i       VGA frame sync, active-low pulse
//   ball_hit_i    one-cycle pulse, ball returned by paddle
//   ball_miss_i   one-cycle pulse, ball passed paddle
//   paddle_up_o   debounced up button level
//   paddle_down_o debounced down button level
//   run_o         ball motion enable (high exactly while in PLAY)
//   serve_o       one-cycle pulse to recentre the ball
//   score_o       saturating hit count
//   lives_o       remaining lives
//   state_o       current FSM state encoding
//   game_over_o   high only in OVER
// -----------------------------------------------------------------------------
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT,
  parameter int SERVE_FRAMES    = SERVE_FRAMES_DEFAULT,
  parameter int LIVES_INIT      = LIVES_INIT_DEFAULT
) (
  input  logic       vga_clk_i,
  input  logic       rst_ni,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       vsync_i,
  input  logic       ball_hit_i,
  input  logic       ball_miss_i,
  output logic       paddle_up_o,
  output logic       paddle_down_o,
  output logic       run_o,
  output logic       serve_o,
  output logic [7:0] score_o,
  output logic [1:0] lives_o,
  output logic [2:0] state_o,
  output logic       game_over_o
);

  localparam logic [7:0] ServeLast = 8'(SERVE_FRAMES);
  localparam logic [1:0] LivesRst  = 2'(LIVES_INIT);

  logic vsyncPrev_q;
  logic frameTick;
  logic upLevel;
  logic downLevel;
  logic upPrev_q;
  logic downPrev_q;
  logic pressEvent;

  pong_state_e state_q;
  logic        run_q;
  logic        serve_q;
  logic        gameOver_q;
  logic [7:0]  score_q;
  logic [1:0]  lives_q;
  logic [7:0]  frameCnt_q;

  // Registered copy of vsync so a falling edge can be seen as one clock
  // where the previous sample was high and the current one is low.
  always_ff @(posedge vga_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsyncPrev_q <= 1'b0;
    end else begin
      vsyncPrev_q <= vsync_i;
    end
  end

  assign frameTick = vsyncPrev_q & ~vsync_i;

  btn_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce_up (
    .clk_i       (vga_clk_i),
    .rst_ni      (rst_ni),
    .frame_tick_i(frameTick),
    .btn_i       (btn_up_i),
    .level_o     (upLevel)
  );

  btn_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce_down (
    .clk_i       (vga_clk_i),
    .rst_ni      (rst_ni),
    .frame_tick_i(frameTick),
    .btn_i       (btn_down_i),
    .level_o     (downLevel)
  );

  // Previous debounced levels for rising-edge detection. Both buttons are
  // ORed into a single press event, so pressing both together counts once.
  always_ff @(posedge vga_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upPrev_q   <= 1'b0;
      downPrev_q <= 1'b0;
    end else begin
      upPrev_q   <= upLevel;
      downPrev_q <= downLevel;
    end
  end

  assign pressEvent = (upLevel & ~upPrev_q) | (downLevel & ~downPrev_q);

  // Game FSM with registered outputs. run, serve and game_over are set on the
  // same edge that moves the state, so they line up with the state register.
  // Hit and miss are only looked at in PLAY; a miss takes priority over a hit
  // arriving in the same cycle.
  always_ff @(posedge vga_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      serve_q    <= 1'b0;
      gameOver_q <= 1'b0;
      score_q    <= 8'd0;
      lives_q    <= LivesRst;
      frameCnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          run_q      <= 1'b0;
          serve_q    <= 1'b0;
          gameOver_q <= 1'b0;
          if (pressEvent) begin
            state_q    <= ST_SERVE;
            score_q    <= 8'd0;
            lives_q    <= LivesRst;
            serve_q    <= 1'b1;
            frameCnt_q <= 8'd0;
          end
        end
        ST_SERVE: begin
          run_q   <= 1'b0;
          serve_q <= 1'b0;
          if (frameTick) begin
            if (frameCnt_q + 8'd1 == ServeLast) begin
              state_q    <= ST_PLAY;
              run_q      <= 1'b1;
              frameCnt_q <= 8'd0;
            end else begin
              frameCnt_q <= frameCnt_q + 8'd1;
            end
          end
        end
        ST_PLAY: begin
          serve_q <= 1'b0;
          if (ball_miss_i) begin
            state_q <= ST_MISS;
            run_q   <= 1'b0;
          end else if (ball_hit_i) begin
            if (score_q != SCORE_MAX) begin
              score_q <= score_q + 8'd1;
            end
          end
        end
        ST_MISS: begin
          run_q   <= 1'b0;
          lives_q <= lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_q    <= ST_OVER;
            gameOver_q <= 1'b1;
          end else begin
            state_q    <= ST_SERVE;
            serve_q    <= 1'b1;
            frameCnt_q <= 8'd0;
          end
        end
        ST_OVER: begin
          run_q   <= 1'b0;
          serve_q <= 1'b0;
          if (pressEvent) begin
            state_q    <= ST_IDLE;
            gameOver_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          run_q      <= 1'b0;
          serve_q    <= 1'b0;
          gameOver_q <= 1'b0;
        end
      endcase
    end
  end

  assign paddle_up_o   = upLevel;
  assign paddle_down_o = downLevel;
  assign run_o         = run_q;
  assign serve_o       = serve_q;
  assign score_o       = score_q;
  assign lives_o       = lives_q;
  assign state_o       = state_q;
  assign game_over_o   = gameOver_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_ctrl
// Self-checking bench for pong_ctrl with DEBOUNCE_FRAMES=3, SERVE_FRAMES=4,
// LIVES_INIT=3. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pong_ctrl;

  logic       clk;
  logic       rstN;
  logic       btnUp;
  logic       btnDown;
  logic       vsync;
  logic       ballHit;
  logic       ballMiss;
  logic       paddleUp;
  logic       paddleDown;
  logic       run;
  logic       serve;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic       gameOver;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic       isFrame;
    logic       hit;
    logic       miss;
    logic [2:0] expState;
    logic       expRun;
    logic       expServe;
    logic [7:0] expScore;
    logic [1:0] expLives;
    logic       expOver;
  } vec_t;

  vec_t vecs[23];

  pong_ctrl #(
    .DEBOUNCE_FRAMES(3),
    .SERVE_FRAMES   (4),
    .LIVES_INIT     (3)
  ) dut (
    .vga_clk_i    (clk),
    .rst_ni       (rstN),
    .btn_up_i     (btnUp),
    .btn_down_i   (btnDown),
    .vsync_i      (vsync),
    .ball_hit_i   (ballHit),
    .ball_miss_i  (ballMiss),
    .paddle_up_o  (paddleUp),
    .paddle_down_o(paddleDown),
    .run_o        (run),
    .serve_o      (serve),
    .score_o      (score),
    .lives_o      (lives),
    .state_o      (state),
    .game_over_o  (gameOver)
  );

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One vsync low pulse; the frame tick lands on the first rising edge.
  task automatic frameStep();
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one table vector: either a full frame or a one-cycle hit/miss pulse.
  task automatic applyStimulus(input vec_t v);
    if (v.isFrame) begin
      frameStep();
    end else begin
      ballHit  = v.hit;
      ballMiss = v.miss;
      @(negedge clk);
      ballHit  = 1'b0;
      ballMiss = 1'b0;
    end
  endtask

  task automatic checkGame(input string tag, input int expState, input int expRun,
                           input int expServe, input int expScore, input int expLives,
                           input int expOver);
    checkOutput({tag, ".state"}, state, expState);
    checkOutput({tag, ".run"}, run, expRun);
    checkOutput({tag, ".serve"}, serve, expServe);
    checkOutput({tag, ".score"}, score, expScore);
    checkOutput({tag, ".lives"}, lives, expLives);
    checkOutput({tag, ".game_over"}, gameOver, expOver);
  endtask

  initial begin
    // isFrame hit miss state run serve score lives over
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'd1, 2'd3, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'd2, 2'd3, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'd3, 2'd3, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'd4, 2'd3, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'd5, 2'd3, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 8'd5, 2'd3, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'd5, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'd5, 2'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'd5, 2'd2, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd5, 2'd2, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd5, 2'd2, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd5, 2'd2, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd5, 2'd2, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'd5, 2'd2, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'd5, 2'd1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd5, 2'd1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd5, 2'd1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd5, 2'd1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd5, 2'd1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'd5, 2'd1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'd5, 2'd0, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 8'd5, 2'd0, 1'b1};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'd5, 2'd0, 1'b1};

    rstN     = 1'b1;
    btnUp    = 1'b0;
    btnDown  = 1'b0;
    vsync    = 1'b1;
    ballHit  = 1'b0;
    ballMiss = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 rstN = 1'b0;
    #1;
    checkGame("reset", 0, 0, 0, 0, 3, 0);
    checkOutput("reset.paddle_up", paddleUp, 0);
    checkOutput("reset.paddle_down", paddleDown, 0);
    waitCycles(2);
    rstN = 1'b1;
    waitCycles(2);

    // Two-frame glitch followed by an agreeing frame must not move the level.
    btnUp = 1'b1;
    waitCycles(3);
    frameStep();
    frameStep();
    checkOutput("glitch.paddle_up", paddleUp, 0);
    btnUp = 1'b0;
    waitCycles(3);
    frameStep();
    checkOutput("glitch_clear.paddle_up", paddleUp, 0);
    checkOutput("glitch.state", state, 0);

    // Proper three-frame press: level rises on the third tick and starts a game.
    btnUp = 1'b1;
    waitCycles(3);
    frameStep();
    checkOutput("press1.paddle_up", paddleUp, 0);
    frameStep();
    checkOutput("press2.paddle_up", paddleUp, 0);
    frameStep();
    checkOutput("press3.paddle_up", paddleUp, 1);
    checkGame("start", 1, 0, 1, 0, 3, 0);
    waitCycles(1);
    checkOutput("start.serve_end", serve, 0);

    // Serve countdown: PLAY only after the fourth tick.
    for (int f = 1; f <= 4; f++) begin
      frameStep();
      checkOutput($sformatf("serve_f%0d.state", f), state, (f == 4) ? 2 : 1);
      checkOutput($sformatf("serve_f%0d.run", f), run, (f == 4) ? 1 : 0);
    end

    // Table-driven play: hits, hit+miss priority, ignored pulses, lives to zero.
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      checkGame($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expRun,
                vecs[i].expServe, vecs[i].expScore, vecs[i].expLives, vecs[i].expOver);
    end

    // Press in OVER returns to IDLE with score and lives untouched.
    btnDown = 1'b1;
    waitCycles(3);
    repeat (3) frameStep();
    checkOutput("over_press.paddle_down", paddleDown, 1);
    checkGame("over_press", 0, 0, 0, 5, 0, 0);

    // Release (no event), then press again for a fresh game.
    btnDown = 1'b0;
    waitCycles(3);
    repeat (3) frameStep();
    checkOutput("release.paddle_down", paddleDown, 0);
    checkOutput("release.state", state, 0);
    btnDown = 1'b1;
    waitCycles(3);
    repeat (3) frameStep();
    checkGame("new_game", 1, 0, 1, 0, 3, 0);

    // Into PLAY, then saturate the score.
    repeat (4) frameStep();
    checkOutput("sat_play.state", state, 2);
    ballHit = 1'b1;
    waitCycles(255);
    checkOutput("sat255.score", score, 255);
    waitCycles(1);
    ballHit = 1'b0;
    checkOutput("sat256.score", score, 255);
    waitCycles(1);
    checkOutput("sat_hold.state", state, 2);
    checkOutput("sat_hold.run", run, 1);

    // Asynchronous reset mid-cycle during PLAY.
    #2 rstN = 1'b0;
    #1;
    checkGame("play_reset", 0, 0, 0, 0, 3, 0);
    checkOutput("play_reset.paddle_up", paddleUp, 0);
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post_reset%0d.state", c), state, 0);
      checkOutput($sformatf("post_reset%0d.serve", c), serve, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
